// File: rtl/sqr_iter_ctrl.sv
// Repeated-squaring engine: c = a^(2^k) mod f in GF(2^M), one squaring per clock.
// A combinational classic squarer feeds a registered accumulator under a small start/busy/done FSM.

module classic_squarer #(
   parameter int          M = 163,
   parameter logic [M-1:0] F = 'hC9
) (
   input  logic [M-1:0] a,
   output logic [M-1:0] c
);
   localparam int W = 2 * M - 1;
   localparam logic [W-1:0] POLY = {{(M - 2){1'b0}}, 1'b1, F};

   logic [W-1:0] prod;

   // Squaring in GF(2) spreads the bits; reduction folds from the top so folded bits get revisited.
   always_comb begin
      prod = '0;
      for (int i = 0; i < M; i++) begin
         prod[2 * i] = a[i];
      end
      for (int i = W - 1; i >= M; i--) begin
         if (prod[i]) begin
            prod = prod ^ (POLY << (i - M));
         end
      end
   end

   assign c = prod[M-1:0];
endmodule

// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | one squaring per cycle, cnt counts down to 1
// DONE  | c valid, done pulse; always returns to IDLE
module sqr_iter_ctrl #(
   parameter int           M     = 163,
   parameter logic [M-1:0] F     = 'hC9,
   parameter int           CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [M-1:0]     a,
   input  logic [CNT_W-1:0] k,
   output logic             busy,
   output logic             done,
   output logic [M-1:0]     c
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [M-1:0]     acc, acc_d, c_d, sq;
   logic [CNT_W-1:0] cnt, cnt_d;

   classic_squarer #(.M(M), .F(F)) u_sqr (
      .a (acc),
      .c (sq)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         c     <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_d;
         cnt   <= cnt_d;
         c     <= c_d;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_d     = acc;
      cnt_d     = cnt;
      c_d       = c;
      case (state)
         IDLE: begin
            if (start) begin
               acc_d = a;
               cnt_d = k;
               if (k != '0) begin
                  state_nxt = RUN;
               end else begin
                  // Zero squarings: the operand itself is the result.
                  state_nxt = DONE;
                  c_d       = a;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               acc_d = sq;
               cnt_d = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_nxt = DONE;
                  c_d       = sq;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
endmodule
